// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - shared types for the IF->ID skid stage
package ibex_pkg;

    localparam logic [1:0] OPCODE_C_MASK = 2'b11;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        is_c;
        logic        err;
        logic        err_plus2;
    } if_id_entry_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/ibex_if_id_skid.sv
// rtl/ibex_if_id_skid.sv - IF->ID register stage with 2-entry skid buffer
module ibex_if_id_skid
    import ibex_pkg::*;
#(
    parameter logic ResetAll  = 1'b0,
    parameter int   StallCntW = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 fetch_valid_i,
    output logic                 fetch_ready_o,
    input  logic [31:0]          fetch_rdata_i,
    input  logic [31:0]          fetch_addr_i,
    input  logic                 fetch_err_i,
    input  logic                 fetch_err_plus2_i,
    input  logic                 flush_i,
    input  logic                 halt_i,
    output logic                 id_valid_o,
    input  logic                 id_ready_i,
    output logic [31:0]          id_instr_o,
    output logic [31:0]          id_pc_o,
    output logic                 id_is_compressed_o,
    output logic                 id_fetch_err_o,
    output logic                 id_fetch_err_plus2_o,
    output logic [StallCntW-1:0] stall_cnt_o,
    input  logic                 stall_cnt_clr_i
);

    localparam logic [StallCntW-1:0] CntMax = {StallCntW{1'b1}};

    // A compressed instr cannot own an error that lies only in the upper half.
    function automatic if_id_entry_t format_entry(input logic [31:0] rdata,
                                                  input logic [31:0] addr,
                                                  input logic        err,
                                                  input logic        err_plus2);
        if_id_entry_t e;
        e.is_c      = (rdata[1:0] != OPCODE_C_MASK);
        e.instr     = e.is_c ? {16'h0000, rdata[15:0]} : rdata;
        e.pc        = addr;
        e.err       = err & ~(e.is_c & err_plus2);
        e.err_plus2 = err_plus2 & ~e.is_c & err;
        return e;
    endfunction

    skid_state_e  state_q, state_d;
    if_id_entry_t main_q, main_d, skid_q, skid_d, fetch_entry;
    logic         in_hs, out_hs, load_main, load_skid, shift_skid;
    logic [StallCntW-1:0] stall_cnt_q;

    assign fetch_entry = format_entry(fetch_rdata_i, fetch_addr_i, fetch_err_i, fetch_err_plus2_i);
    assign in_hs       = fetch_valid_i & fetch_ready_o;
    assign out_hs      = id_valid_o & id_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SKID_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: if (in_hs) state_d = SKID_ONE;
                SKID_ONE: begin
                    if (in_hs && !out_hs)      state_d = SKID_FULL;
                    else if (!in_hs && out_hs) state_d = SKID_EMPTY;
                end
                SKID_FULL: if (out_hs) state_d = SKID_ONE;
                default:   state_d = SKID_EMPTY;
            endcase
        end
    end

    // Ready comes from registered state only, so ID ready never reaches IF combinationally.
    always_comb begin
        fetch_ready_o = (state_q != SKID_FULL) & ~halt_i;
        id_valid_o    = (state_q != SKID_EMPTY);
        load_main     = 1'b0;
        load_skid     = 1'b0;
        shift_skid    = 1'b0;
        if (!flush_i) begin
            load_main  = in_hs & ((state_q == SKID_EMPTY) | ((state_q == SKID_ONE) & out_hs));
            load_skid  = in_hs & (state_q == SKID_ONE) & ~out_hs;
            shift_skid = out_hs & (state_q == SKID_FULL);
        end
    end

    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (load_main) begin
            main_d = fetch_entry;
        end else if (shift_skid) begin
            main_d = skid_q;
        end
        if (load_skid) begin
            skid_d = fetch_entry;
        end
    end

    if (ResetAll) begin : g_dp_reset
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                main_q <= '0;
                skid_q <= '0;
            end else begin
                main_q <= main_d;
                skid_q <= skid_d;
            end
        end
    end else begin : g_dp_noreset
        always_ff @(posedge clk_i) begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (stall_cnt_clr_i) begin
            stall_cnt_q <= '0;
        end else if (id_valid_o && !id_ready_i && (stall_cnt_q != CntMax)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign id_instr_o           = main_q.instr;
    assign id_pc_o              = main_q.pc;
    assign id_is_compressed_o   = main_q.is_c;
    assign id_fetch_err_o       = main_q.err;
    assign id_fetch_err_plus2_o = main_q.err_plus2;
    assign stall_cnt_o          = stall_cnt_q;

    a_no_accept_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !((state_q == SKID_FULL) && in_hs));

    a_id_stable_on_stall: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (id_valid_o && !id_ready_i && !flush_i) |=>
        (id_valid_o && $stable(id_instr_o) && $stable(id_pc_o) && $stable(id_is_compressed_o)
         && $stable(id_fetch_err_o) && $stable(id_fetch_err_plus2_o)));

endmodule

// File: tb/tb_ibex_if_id_skid.sv
// tb/tb_ibex_if_id_skid.sv - directed self-checking bench for ibex_if_id_skid
module tb_ibex_if_id_skid;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        fetch_valid_i, fetch_err_i, fetch_err_plus2_i;
    logic [31:0] fetch_rdata_i, fetch_addr_i;
    logic        flush_i, halt_i, id_ready_i, stall_cnt_clr_i;

    logic        fetch_ready_o, id_valid_o, id_is_compressed_o, id_fetch_err_o, id_fetch_err_plus2_o;
    logic [31:0] id_instr_o, id_pc_o;
    logic [15:0] stall_cnt_o;

    logic        r_fetch_ready, r_id_valid, r_is_c, r_err, r_err_plus2;
    logic [31:0] r_instr, r_pc;
    logic [3:0]  r_stall_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    ibex_if_id_skid #(.ResetAll(1'b0), .StallCntW(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
        .fetch_rdata_i(fetch_rdata_i), .fetch_addr_i(fetch_addr_i),
        .fetch_err_i(fetch_err_i), .fetch_err_plus2_i(fetch_err_plus2_i),
        .flush_i(flush_i), .halt_i(halt_i),
        .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
        .id_instr_o(id_instr_o), .id_pc_o(id_pc_o),
        .id_is_compressed_o(id_is_compressed_o), .id_fetch_err_o(id_fetch_err_o),
        .id_fetch_err_plus2_o(id_fetch_err_plus2_o),
        .stall_cnt_o(stall_cnt_o), .stall_cnt_clr_i(stall_cnt_clr_i)
    );

    ibex_if_id_skid #(.ResetAll(1'b1), .StallCntW(4)) dut_rst (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .fetch_valid_i(fetch_valid_i), .fetch_ready_o(r_fetch_ready),
        .fetch_rdata_i(fetch_rdata_i), .fetch_addr_i(fetch_addr_i),
        .fetch_err_i(fetch_err_i), .fetch_err_plus2_i(fetch_err_plus2_i),
        .flush_i(flush_i), .halt_i(halt_i),
        .id_valid_o(r_id_valid), .id_ready_i(id_ready_i),
        .id_instr_o(r_instr), .id_pc_o(r_pc),
        .id_is_compressed_o(r_is_c), .id_fetch_err_o(r_err),
        .id_fetch_err_plus2_o(r_err_plus2),
        .stall_cnt_o(r_stall_cnt), .stall_cnt_clr_i(stall_cnt_clr_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] rdata, input logic [31:0] addr,
                         input logic err, input logic err_plus2);
        fetch_valid_i     = v;
        fetch_rdata_i     = rdata;
        fetch_addr_i      = addr;
        fetch_err_i       = err;
        fetch_err_plus2_i = err_plus2;
    endtask

    logic [31:0] words [4];

    initial begin
        words[0] = 32'h0010_0093; words[1] = 32'h0020_0113;
        words[2] = 32'h0030_0193; words[3] = 32'h0040_0213;
        rst_ni = 1'b0;
        offer(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        flush_i = 1'b0; halt_i = 1'b0; id_ready_i = 1'b0; stall_cnt_clr_i = 1'b0;
        #1;
        check("rst_id_valid", {31'b0, id_valid_o}, 32'd0);
        check("rst_fetch_ready", {31'b0, fetch_ready_o}, 32'd1);
        check("rst_stall_cnt", {16'b0, stall_cnt_o}, 32'd0);
        check("rst_all_instr", r_instr, 32'd0);
        check("rst_all_pc", r_pc, 32'd0);
        check("rst_all_flags", {29'b0, r_is_c, r_err, r_err_plus2}, 32'd0);
        halt_i = 1'b1; #1;
        check("rst_halt_ready", {31'b0, fetch_ready_o}, 32'd0);
        halt_i = 1'b0;
        #10 rst_ni = 1'b1;
        tick();

        // Streaming with ID always ready
        id_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, words[i], 32'h100 + 32'(4 * i), 1'b0, 1'b0);
            #1;
            check("stream_ready", {31'b0, fetch_ready_o}, 32'd1);
            tick();
            check("stream_valid", {31'b0, id_valid_o}, 32'd1);
            check("stream_instr", id_instr_o, words[i]);
            check("stream_pc", id_pc_o, 32'h100 + 32'(4 * i));
        end
        offer(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        check("stream_drained", {31'b0, id_valid_o}, 32'd0);
        check("stream_stall", {16'b0, stall_cnt_o}, 32'd0);

        // Back-pressure: three offered, two accepted
        id_ready_i = 1'b0;
        offer(1'b1, 32'h0050_0293, 32'h200, 1'b0, 1'b0);
        tick();
        check("bp_a_visible", id_instr_o, 32'h0050_0293);
        offer(1'b1, 32'h0060_0313, 32'h204, 1'b0, 1'b0);
        #1;
        check("bp_ready_2nd", {31'b0, fetch_ready_o}, 32'd1);
        tick();
        offer(1'b1, 32'h0070_0393, 32'h208, 1'b0, 1'b0);
        #1;
        check("bp_ready_3rd", {31'b0, fetch_ready_o}, 32'd0);
        tick();
        check("bp_main_held", id_instr_o, 32'h0050_0293);
        check("bp_stall_2", {16'b0, stall_cnt_o}, 32'd2);
        offer(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        check("bp_stall_3", {16'b0, stall_cnt_o}, 32'd3);
        id_ready_i = 1'b1;
        tick();
        check("bp_order_b", id_instr_o, 32'h0060_0313);
        check("bp_order_b_pc", id_pc_o, 32'h204);
        check("bp_ready_back", {31'b0, fetch_ready_o}, 32'd1);
        tick();
        check("bp_c_absent", {31'b0, id_valid_o}, 32'd0);
        check("bp_stall_hold", {16'b0, stall_cnt_o}, 32'd3);

        // Compressed tagging and error attribution
        offer(1'b1, 32'hABCD_4501, 32'h300, 1'b0, 1'b0);
        tick();
        check("c_instr", id_instr_o, 32'h0000_4501);
        check("c_is_c", {31'b0, id_is_compressed_o}, 32'd1);
        offer(1'b1, 32'h0010_0093, 32'h302, 1'b0, 1'b0);
        tick();
        check("u_instr", id_instr_o, 32'h0010_0093);
        check("u_is_c", {31'b0, id_is_compressed_o}, 32'd0);
        offer(1'b1, 32'h0000_4501, 32'h306, 1'b1, 1'b1);
        tick();
        check("c_err_p2", {30'b0, id_fetch_err_o, id_fetch_err_plus2_o}, 32'b00);
        offer(1'b1, 32'h0010_0093, 32'h308, 1'b1, 1'b1);
        tick();
        check("u_err_p2", {30'b0, id_fetch_err_o, id_fetch_err_plus2_o}, 32'b11);
        offer(1'b1, 32'h0010_0093, 32'h30C, 1'b1, 1'b0);
        tick();
        check("u_err_only", {30'b0, id_fetch_err_o, id_fetch_err_plus2_o}, 32'b10);
        offer(1'b1, 32'h0000_4501, 32'h310, 1'b1, 1'b0);
        tick();
        check("c_err_only", {30'b0, id_fetch_err_o, id_fetch_err_plus2_o}, 32'b10);
        offer(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();

        // Halt blocks intake but lets the held entry drain
        id_ready_i = 1'b0;
        offer(1'b1, 32'h0080_0413, 32'h400, 1'b0, 1'b0);
        tick();
        halt_i = 1'b1;
        offer(1'b1, 32'h0090_0493, 32'h404, 1'b0, 1'b0);
        #1;
        check("halt_ready", {31'b0, fetch_ready_o}, 32'd0);
        tick();
        check("halt_valid", {31'b0, id_valid_o}, 32'd1);
        check("halt_instr", id_instr_o, 32'h0080_0413);
        halt_i = 1'b0; id_ready_i = 1'b1;
        offer(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        check("halt_drained", {31'b0, id_valid_o}, 32'd0);

        // Flush while FULL with a word offered
        id_ready_i = 1'b0;
        offer(1'b1, 32'h00A0_0513, 32'h500, 1'b0, 1'b0);
        tick();
        offer(1'b1, 32'h00B0_0593, 32'h504, 1'b0, 1'b0);
        tick();
        flush_i = 1'b1;
        offer(1'b1, 32'h00C0_0613, 32'h508, 1'b0, 1'b0);
        tick();
        check("flush_valid", {31'b0, id_valid_o}, 32'd0);
        check("flush_ready", {31'b0, fetch_ready_o}, 32'd1);
        flush_i = 1'b0; id_ready_i = 1'b1;
        offer(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        check("flush_absent", {31'b0, id_valid_o}, 32'd0);

        // Saturation on the 4-bit counter instance, clear priority on both
        id_ready_i = 1'b0; stall_cnt_clr_i = 1'b1;
        offer(1'b1, 32'h00D0_0693, 32'h600, 1'b0, 1'b0);
        tick();
        check("clr_cnt", {16'b0, stall_cnt_o}, 32'd0);
        stall_cnt_clr_i = 1'b0;
        offer(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (14) tick();
        check("sat_fe", {28'b0, r_stall_cnt}, 32'hE);
        check("cnt_14", {16'b0, stall_cnt_o}, 32'd14);
        repeat (3) tick();
        check("sat_ff", {28'b0, r_stall_cnt}, 32'hF);
        check("cnt_17", {16'b0, stall_cnt_o}, 32'd17);
        stall_cnt_clr_i = 1'b1;
        tick();
        check("clr_wins_sat", {28'b0, r_stall_cnt}, 32'd0);
        check("clr_wins", {16'b0, stall_cnt_o}, 32'd0);
        stall_cnt_clr_i = 1'b0;

        // Asynchronous reset mid-operation
        #2 rst_ni = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, id_valid_o}, 32'd0);
        check("async_rst_pc", r_pc, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
